// File: rtl/id_arbiter_tx_pkg.sv
// Shared ID-arbitration types, used by both transmit and receive ID logic.
package id_arbiter_tx_pkg;
  localparam int ID_LEN_DEFAULT = 11;

  typedef enum logic [2:0] {
    s_idle,
    s_load,
    s_drive,
    s_sample,
    s_done,
    s_lost,
    s_error
  } id_state_e;
endpackage

// File: rtl/id_arbiter_tx_if.sv
// Handshake/bus bundle between a frame controller (master) and the ID transmitter (slave).
interface id_arbiter_tx_if;
  logic        enable;
  logic [31:0] id;
  logic        txPulse;
  logic        samplePulse;
  logic        dIn;
  logic        dOut;
  logic        txActive;
  logic        idSendComplete;
  logic        arbLost;
  logic        bitError;

  modport master (
    output enable, id, txPulse, samplePulse, dIn,
    input  dOut, txActive, idSendComplete, arbLost, bitError
  );

  modport slave (
    input  enable, id, txPulse, samplePulse, dIn,
    output dOut, txActive, idSendComplete, arbLost, bitError
  );
endinterface

// File: rtl/id_shift_out.sv
// MSB-first ID shift register with a bit counter; loaded at frame start, shifted per won bit.
module id_shift_out
  import id_arbiter_tx_pkg::*;
#(
  parameter int ID_LEN = ID_LEN_DEFAULT
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [ID_LEN-1:0] id_i,
  output logic              msb_o,
  output logic [4:0]        cnt_o
);
  logic [ID_LEN-1:0] sr_q, sr_d;
  logic [4:0]        cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sr_d  = id_i;
      cnt_d = '0;
    end else if (shift_i) begin
      // Recessive fill keeps the register well-defined for ID_LEN == 1 too.
      sr_d  = (sr_q << 1) | ID_LEN'(1);
      cnt_d = cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      sr_q  <= '1;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign msb_o = sr_q[ID_LEN-1];
  assign cnt_o = cnt_q;
endmodule

// File: rtl/id_arbiter_tx.sv
// Bitwise ID arbitration transmitter: drives ID bits on txPulse, checks readback on samplePulse.
module id_arbiter_tx
  import id_arbiter_tx_pkg::*;
#(
  parameter int ID_LEN = ID_LEN_DEFAULT
) (
  input  logic           clk,
  input  logic           resetN,
  id_arbiter_tx_if.slave bus
);
  localparam logic [4:0] LAST_BIT = 5'(ID_LEN - 1);

  id_state_e  state_q;
  logic       dout_q, din_q, active_q, done_q, lost_q, err_q;
  logic       load, shift, msb;
  logic [4:0] cnt;

  assign load  = (state_q == s_idle) && bus.enable;
  assign shift = (state_q == s_sample) && bus.enable && (din_q == dout_q);

  id_shift_out #(.ID_LEN(ID_LEN)) u_shift (
    .clk     (clk),
    .resetN  (resetN),
    .load_i  (load),
    .shift_i (shift),
    .id_i    (bus.id[ID_LEN-1:0]),
    .msb_o   (msb),
    .cnt_o   (cnt)
  );

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q  <= s_idle;
      dout_q   <= 1'b1;
      din_q    <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      lost_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (bus.samplePulse) din_q <= bus.dIn;
      case (state_q)
        s_idle: if (bus.enable) begin
          state_q  <= s_load;
          active_q <= 1'b1;
        end
        s_load, s_drive, s_sample: begin
          if (!bus.enable) begin
            state_q  <= s_idle;
            dout_q   <= 1'b1;
            active_q <= 1'b0;
          end else if (state_q == s_load) begin
            // A coincident samplePulse wins the cycle; the txPulse is dropped.
            if (bus.txPulse && !bus.samplePulse) begin
              state_q <= s_drive;
              dout_q  <= msb;
            end
          end else if (state_q == s_drive) begin
            if (bus.samplePulse) state_q <= s_sample;
          end else if (din_q == dout_q) begin
            if (cnt == LAST_BIT) begin
              state_q  <= s_done;
              dout_q   <= 1'b1;
              active_q <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              state_q <= s_load;
            end
          end else begin
            state_q  <= dout_q ? s_lost : s_error;
            lost_q   <= dout_q;
            err_q    <= ~dout_q;
            dout_q   <= 1'b1;
            active_q <= 1'b0;
          end
        end
        s_done, s_lost, s_error: if (!bus.enable) begin
          state_q <= s_idle;
          done_q  <= 1'b0;
          lost_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: begin
          state_q  <= s_idle;
          dout_q   <= 1'b1;
          active_q <= 1'b0;
          done_q   <= 1'b0;
          lost_q   <= 1'b0;
          err_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dOut           = dout_q;
  assign bus.txActive       = active_q;
  assign bus.idSendComplete = done_q;
  assign bus.arbLost        = lost_q;
  assign bus.bitError       = err_q;
endmodule
